// File: rtl/pool_result_writeback_if.sv
// Handshake bundle between the pooling controller, pool_result_writeback and paged PIM memory.
// The master modport drives the requests and the memory-ready input; the slave is the writeback stage.
interface pool_result_writeback_if #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned Address_Size = 16,
    parameter int unsigned NUM_PAGES    = 64
);
    logic                    start;
    logic [Address_Size-1:0] base_addr;
    logic [Address_Size-1:0] num_results;
    logic [DATA_WIDTH-1:0]   din;
    logic                    din_valid;
    logic                    mem_ready;
    logic                    mem_we;
    logic [NUM_PAGES-1:0]    mem_page_we;
    logic [Address_Size-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic                    busy;
    logic                    done;
    logic                    overflow;

    modport master (
        output start, base_addr, num_results, din, din_valid, mem_ready,
        input  mem_we, mem_page_we, mem_addr, mem_wdata, busy, done, overflow
    );

    modport slave (
        input  start, base_addr, num_results, din, din_valid, mem_ready,
        output mem_we, mem_page_we, mem_addr, mem_wdata, busy, done, overflow
    );
endinterface

// File: rtl/pool_result_writeback.sv
// Buffers pooled results in a small FIFO and writes them sequentially into paged PIM memory.
// Define POOL_WB_RELU_EN to zero negative (sign-bit set) words as they are pushed.
module pool_result_writeback #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned Address_Size = 16,
    parameter int unsigned NUM_PAGES    = 64,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input logic                    clk,
    input logic                    rst_n,
    pool_result_writeback_if.slave wb_io
);
    localparam int unsigned PageW = $clog2(NUM_PAGES);
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                  state_q;
    logic [Address_Size-1:0] base_q, num_q, wr_cnt_q, push_cnt_q;
    logic [PtrW:0]           wr_ptr_q, rd_ptr_q;
    logic [DATA_WIDTH-1:0]   fifo_q [FIFO_DEPTH];
    logic                    overflow_q, mem_we_q;
    logic [NUM_PAGES-1:0]    mem_page_we_q;
    logic [Address_Size-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q;

    logic                    run, empty, full, want_push, push, pop, ovf_evt;
    logic [DATA_WIDTH-1:0]   din_word, pop_data;
    logic [Address_Size-1:0] pop_addr;
    logic [PageW-1:0]        pop_page;

    always_comb begin
`ifdef POOL_WB_RELU_EN
        din_word = wb_io.din[DATA_WIDTH-1] ? '0 : wb_io.din;
`else
        din_word = wb_io.din;
`endif
        run   = (state_q == StRun);
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
        // Words beyond the programmed count are silently ignored, never counted as overflow.
        want_push = run && wb_io.din_valid && (push_cnt_q < num_q);
        pop       = run && wb_io.mem_ready && (wr_cnt_q < num_q) && (!empty || want_push);
        push      = want_push && (!full || pop);
        ovf_evt   = want_push && full && !pop;
        // An empty FIFO forwards the incoming word so the write lands one cycle after din_valid.
        pop_data  = empty ? din_word : fifo_q[rd_ptr_q[PtrW-1:0]];
        pop_addr  = base_q + wr_cnt_q;
        pop_page  = pop_addr[Address_Size-1 -: PageW];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q[PtrW-1:0]] <= din_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            base_q        <= '0;
            num_q         <= '0;
            wr_cnt_q      <= '0;
            push_cnt_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            overflow_q    <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_page_we_q <= '0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
        end else begin
            mem_we_q      <= pop;
            mem_page_we_q <= pop ? (NUM_PAGES'(1) << pop_page) : '0;
            if (pop) begin
                mem_addr_q  <= pop_addr;
                mem_wdata_q <= pop_data;
                rd_ptr_q    <= rd_ptr_q + 1'b1;
                wr_cnt_q    <= wr_cnt_q + 1'b1;
            end
            if (push) begin
                wr_ptr_q   <= wr_ptr_q + 1'b1;
                push_cnt_q <= push_cnt_q + 1'b1;
            end
            if (ovf_evt) begin
                overflow_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (wb_io.start) begin
                        base_q     <= wb_io.base_addr;
                        num_q      <= wb_io.num_results;
                        wr_cnt_q   <= '0;
                        push_cnt_q <= '0;
                        wr_ptr_q   <= '0;
                        rd_ptr_q   <= '0;
                        overflow_q <= 1'b0;
                        state_q    <= (wb_io.num_results == '0) ? StDone : StRun;
                    end
                end
                // Leave one cycle after the final write so done trails the last mem_we.
                StRun:   if (wr_cnt_q == num_q) state_q <= StDone;
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign wb_io.mem_we      = mem_we_q;
    assign wb_io.mem_page_we = mem_page_we_q;
    assign wb_io.mem_addr    = mem_addr_q;
    assign wb_io.mem_wdata   = mem_wdata_q;
    assign wb_io.busy        = (state_q == StRun);
    assign wb_io.done        = (state_q == StDone);
    assign wb_io.overflow    = overflow_q;
endmodule

// File: tb/tb_pool_result_writeback.sv
// Bench for pool_result_writeback: directed scenarios plus random traffic, every cycle compared
// against a queue-based transaction model.
module tb_pool_result_writeback;
    localparam int unsigned DW = 32, AW = 16, NP = 64, DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pool_result_writeback_if #(.DATA_WIDTH(DW), .Address_Size(AW), .NUM_PAGES(NP)) bus ();

    pool_result_writeback #(
        .DATA_WIDTH  (DW),
        .Address_Size(AW),
        .NUM_PAGES   (NP),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .wb_io(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Reference model: phase, accepted-word queue, and the expected output registers.
    typedef enum int {MIdle, MRun, MDone} phase_e;
    phase_e      ph = MIdle;
    logic [31:0] q[$];
    int unsigned m_base, m_num, m_wr, m_acc;
    bit          m_ovf, e_we;
    logic [15:0] e_addr;
    logic [31:0] e_wdata;
    logic [63:0] e_page;

    function automatic logic [31:0] relu(input logic [31:0] w);
`ifdef POOL_WB_RELU_EN
        return w[31] ? 32'h0 : w;
`else
        return w;
`endif
    endfunction

    task automatic step(input bit rn, input bit st, input logic [15:0] ba, input logic [15:0] n,
                        input bit dv, input logic [31:0] d, input bit mr);
        bit incoming, wr_ok;
        @(negedge clk);
        rst_n = rn;
        bus.start = st;
        bus.base_addr = ba;
        bus.num_results = n;
        bus.din_valid = dv;
        bus.din = d;
        bus.mem_ready = mr;
        if (!rn) begin
            ph = MIdle; q.delete(); m_ovf = 0;
            e_we = 0; e_page = '0; e_addr = '0; e_wdata = '0;
            m_base = 0; m_num = 0; m_wr = 0; m_acc = 0;
        end else begin
            e_we = 0;
            e_page = '0;
            case (ph)
                MIdle: if (st) begin
                    m_base = ba; m_num = n; m_wr = 0; m_acc = 0; q.delete(); m_ovf = 0;
                    ph = (n == 0) ? MDone : MRun;
                end
                MDone: ph = MIdle;
                default: if (m_wr == m_num) ph = MDone;
                else begin
                    incoming = dv && (m_acc < m_num);
                    wr_ok = mr && (q.size() > 0 || incoming);
                    if (incoming) begin
                        if (q.size() < DEPTH || wr_ok) begin
                            q.push_back(relu(d));
                            m_acc++;
                        end else m_ovf = 1;
                    end
                    if (wr_ok) begin
                        e_addr = 16'(m_base + m_wr);
                        e_wdata = q.pop_front();
                        e_page = 64'd1 << (e_addr >> 10);
                        e_we = 1;
                        m_wr++;
                    end
                end
            endcase
        end
        @(posedge clk);
        #1;
        check("mem_we", bus.mem_we, e_we);
        check("mem_page_we", bus.mem_page_we, e_page);
        check("mem_addr", bus.mem_addr, e_addr);
        check("mem_wdata", bus.mem_wdata, e_wdata);
        check("busy", bus.busy, ph == MRun);
        check("done", bus.done, ph == MDone);
        check("overflow", bus.overflow, m_ovf);
    endtask

    task automatic idle(input int cycles, input bit mr);
        for (int i = 0; i < cycles; i++) step(1, 0, 16'h0, 16'h0, 0, 32'h0, mr);
    endtask

    task automatic feed(input int cycles, input bit mr);
        for (int i = 0; i < cycles; i++) step(1, 0, 16'h0, 16'h0, 1, $urandom, mr);
    endtask

    logic [31:0] t1_words [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};

    initial begin
        bus.start = 0; bus.base_addr = '0; bus.num_results = '0;
        bus.din = '0; bus.din_valid = 0; bus.mem_ready = 0;
        step(0, 0, 16'h0, 16'h0, 0, 32'h0, 0);
        step(0, 0, 16'h0, 16'h0, 0, 32'h0, 0);

        // Back-to-back pushes with memory ready.
        step(1, 1, 16'h0100, 16'd4, 0, 32'h0, 1);
        for (int i = 0; i < 4; i++) step(1, 0, 16'h0, 16'h0, 1, t1_words[i], 1);
        idle(3, 1);

        // Memory stalled while six words queue up, then drains.
        step(1, 1, 16'h0300, 16'd6, 0, 32'h0, 0);
        feed(6, 0);
        idle(4, 0);
        idle(10, 1);

        // Overflow: ten words into an eight-entry FIFO, then reset.
        step(1, 1, 16'h0400, 16'd12, 0, 32'h0, 0);
        feed(10, 0);
        idle(4, 0);
        step(0, 0, 16'h0, 16'h0, 0, 32'h0, 0);

        // Address and page wrap.
        step(1, 1, 16'hFFFE, 16'd3, 0, 32'h0, 1);
        feed(3, 1);
        idle(3, 1);

        // Reset mid-transfer, then restart at 0x0200.
        step(1, 1, 16'h0500, 16'd5, 0, 32'h0, 1);
        feed(2, 1);
        step(0, 0, 16'h0, 16'h0, 1, 32'h12345678, 1);
        step(1, 1, 16'h0200, 16'd3, 0, 32'h0, 1);
        feed(3, 1);
        idle(3, 1);

        // Negative word, with or without ReLU.
        step(1, 1, 16'h0010, 16'd1, 0, 32'h0, 1);
        step(1, 0, 16'h0, 16'h0, 1, 32'hBF800000, 1);
        idle(3, 1);

        // Zero-length job goes straight to done.
        step(1, 1, 16'h0020, 16'd0, 0, 32'h0, 1);
        idle(2, 1);

        // Random jobs with stray starts, bursty input, flaky memory and rare resets.
        for (int j = 0; j < 40; j++) begin
            int budget;
            step(1, 1, 16'($urandom), 16'($urandom_range(0, 20)), 0, 32'h0, 1);
            budget = 0;
            while (ph != MIdle && budget < 400) begin
                step(($urandom_range(0, 299) != 0), ($urandom_range(0, 15) == 0), 16'($urandom),
                     16'($urandom_range(0, 20)), ($urandom_range(0, 3) != 0), $urandom,
                     ($urandom_range(0, 2) != 0));
                budget++;
            end
            if (ph != MIdle) step(0, 0, 16'h0, 16'h0, 0, 32'h0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
